// File: rtl/iir_mac_scheduler.sv
// Round-robin scheduler that runs y[n] = a*y[n-1] + b*x[n] for N_CH channels
// through one shared 2-cycle signed multiplier and one accumulator.
module iir_mac_scheduler #(
  parameter int               N_CH   = 4,
  parameter int               CH_W   = 2,
  parameter int               Y_W    = 24,
  parameter logic signed [7:0] COEF_A = 8'sd3,
  parameter logic signed [7:0] COEF_B = -8'sd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*8-1:0]   in_data,
  output logic [N_CH-1:0]     in_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Y_W-1:0]      out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_sat,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISS_BX = 3'd1,
    ISS_AY = 3'd2,
    ACC_BX = 3'd3,
    ACC_AY = 3'd4,
    OUT    = 3'd5
  } state_t;

  localparam logic signed [Y_W+8:0] SAT_MAX = {{10{1'b0}}, {(Y_W-1){1'b1}}};
  localparam logic signed [Y_W+8:0] SAT_MIN = {{10{1'b1}}, {(Y_W-1){1'b0}}};

  state_t                   state_r;
  state_t                   state_next_s;
  logic [CH_W-1:0]          rr_r;
  logic [CH_W-1:0]          grant_s;
  logic [CH_W-1:0]          scan_idx_s;
  logic                     grant_valid_s;
  logic                     accept_s;
  logic [7:0]               sel_data_s;
  logic signed [7:0]        x_r;
  logic [CH_W-1:0]          ch_r;
  logic signed [Y_W-1:0]    yp_r;
  logic signed [7:0]        op_a_r;
  logic signed [Y_W-1:0]    op_b_r;
  logic signed [Y_W+7:0]    mul_a_ext_s;
  logic signed [Y_W+7:0]    mul_b_ext_s;
  logic signed [Y_W+7:0]    prod_r;
  logic signed [Y_W+8:0]    acc_r;
  logic signed [Y_W+8:0]    sum_s;
  logic [Y_W:0]             sat_s;
  logic signed [Y_W-1:0]    y_state_r [N_CH];
  logic                     flush_pending_r;
  logic                     out_valid_r;
  logic [Y_W-1:0]           out_data_r;
  logic [CH_W-1:0]          out_ch_r;
  logic                     out_sat_r;

  // Clip to the Y_W signed range; MSB of the result flags a clip.
  function automatic logic [Y_W:0] saturate(input logic signed [Y_W+8:0] v);
    logic [Y_W:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, SAT_MAX[Y_W-1:0]};
    end else if (v < SAT_MIN) begin
      r = {1'b1, SAT_MIN[Y_W-1:0]};
    end else begin
      r = {1'b0, v[Y_W-1:0]};
    end
    return r;
  endfunction

  // Round-robin search starting at rr, wrapping modulo N_CH.
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    scan_idx_s    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(rr_r) + k < N_CH) begin
        scan_idx_s = CH_W'(int'(rr_r) + k);
      end else begin
        scan_idx_s = CH_W'(int'(rr_r) + k - N_CH);
      end
      if (!grant_valid_s && in_valid[scan_idx_s]) begin
        grant_valid_s = 1'b1;
        grant_s       = scan_idx_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // A flush seen in IDLE takes that cycle, so nothing is granted alongside it.
  assign accept_s   = (state_r == IDLE) && !flush_pending_r && !flush && grant_valid_s;
  assign sel_data_s = in_data[8*int'(grant_s) +: 8];

  always_comb begin
    in_ready = '0;
    if (accept_s) begin
      in_ready[grant_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  assign mul_a_ext_s = {{Y_W{op_a_r[7]}}, op_a_r};
  assign mul_b_ext_s = {{8{op_b_r[Y_W-1]}}, op_b_r};
  assign sum_s       = acc_r + {prod_r[Y_W+7], prod_r};
  assign sat_s       = saturate(sum_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = ISS_BX;
        else          state_next_s = IDLE;
      end
      ISS_BX: state_next_s = ISS_AY;
      ISS_AY: state_next_s = ACC_BX;
      ACC_BX: state_next_s = ACC_AY;
      ACC_AY: state_next_s = OUT;
      OUT: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = OUT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: operand/product pipeline, accumulator, channel state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r            <= '0;
      x_r             <= '0;
      ch_r            <= '0;
      yp_r            <= '0;
      op_a_r          <= '0;
      op_b_r          <= '0;
      prod_r          <= '0;
      acc_r           <= '0;
      flush_pending_r <= 1'b0;
      out_valid_r     <= 1'b0;
      out_data_r      <= '0;
      out_ch_r        <= '0;
      out_sat_r       <= 1'b0;
      for (int i = 0; i < N_CH; i++) y_state_r[i] <= '0;
    end else begin
      prod_r <= mul_a_ext_s * mul_b_ext_s;
      if (flush && state_r != IDLE) flush_pending_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < N_CH; i++) y_state_r[i] <= '0;
          end else if (accept_s) begin
            x_r  <= sel_data_s;
            ch_r <= grant_s;
            yp_r <= y_state_r[grant_s];
            if (grant_s == CH_W'(N_CH-1)) rr_r <= '0;
            else                          rr_r <= grant_s + CH_W'(1);
          end
        end
        ISS_BX: begin
          op_a_r <= COEF_B;
          op_b_r <= {{(Y_W-8){x_r[7]}}, x_r};
        end
        ISS_AY: begin
          op_a_r <= COEF_A;
          op_b_r <= yp_r;
        end
        ACC_BX: acc_r <= {prod_r[Y_W+7], prod_r};
        ACC_AY: begin
          y_state_r[ch_r] <= sat_s[Y_W-1:0];
          out_data_r      <= sat_s[Y_W-1:0];
          out_sat_r       <= sat_s[Y_W];
          out_ch_r        <= ch_r;
          out_valid_r     <= 1'b1;
        end
        OUT: begin
          // The write-back already happened, so a deferred flush lands after it.
          if (out_ready) begin
            out_valid_r     <= 1'b0;
            flush_pending_r <= 1'b0;
            if (flush_pending_r || flush) begin
              for (int i = 0; i < N_CH; i++) y_state_r[i] <= '0;
            end
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_sat   = out_sat_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Directed bench for iir_mac_scheduler (N_CH=4, Y_W=24, a=3, b=-4).
module tb_iir_mac_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         in_valid;
  logic [31:0]        in_data;
  logic [3:0]         in_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_data;
  logic [1:0]         out_ch;
  logic               out_sat;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  iir_mac_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Request one sample on ch, optionally pulse flush c cycles after accept, check the result.
  task automatic do_sample(input int ch, input logic [7:0] x, input logic signed [31:0] exp,
                           input logic exp_sat, input int flush_at);
    int w;
    int c;
    in_valid[ch] = 1'b1;
    in_data[ch*8 +: 8] = x;
    #1;
    w = 0;
    while (!in_ready[ch] && w < 40) begin
      @(posedge clk); #1; w++;
    end
    check_val("grant", in_ready[ch], 1);
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      flush = (c == flush_at);
      @(posedge clk); #1; c++;
    end
    flush = 1'b0;
    check_val("latency", c, 4);
    check_val("data", out_data, exp);
    check_val("ch", out_ch, ch);
    check_val("sat", out_sat, exp_sat);
    @(posedge clk); #1;
    check_val("valid_drop", out_valid, 0);
  endtask

  initial begin
    int w;
    int c;
    int acc_cyc;
    int prev_cyc;
    int exp_sat_seq [10];
    exp_sat_seq = '{512, 2048, 6656, 20480, 61952, 186368, 559616, 1679360, 5038592, 8388607};

    // Reset state and basic ch0 sequence
    do_reset();
    check_val("rst_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_ch", out_ch, 0);
    check_val("rst_sat", out_sat, 0);
    check_val("rst_ready", in_ready, 0);
    do_sample(0, 8'sd1, -4, 1'b0, -1);
    do_sample(0, 8'sd2, -20, 1'b0, -1);

    // All channels requesting: round-robin order and 6-cycle spacing
    do_reset();
    in_valid = 4'b1111;
    in_data  = {4{8'sd1}};
    prev_cyc = 0;
    #1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (in_ready == 4'b0000 && w < 40) begin
        @(posedge clk); #1; w++;
      end
      check_val("rr_grant", in_ready, 1 << (k % 4));
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (k > 0) check_val("spacing", acc_cyc - prev_cyc, 6);
      prev_cyc = acc_cyc;
      c = 0;
      while (!out_valid && c < 20) begin
        @(posedge clk); #1; c++;
      end
      check_val("rr_latency", c, 4);
      check_val("rr_ch", out_ch, k % 4);
      check_val("rr_data", out_data, (k < 4) ? -4 : -16);
      @(posedge clk); #1;
    end
    in_valid = '0;

    // Growing state through saturation
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_sample(0, 8'h80, exp_sat_seq[k], (k == 9), -1);
    end

    // Backpressure: result must hold while out_ready is low
    do_reset();
    out_ready = 1'b0;
    in_valid = 4'b0110;
    in_data  = {8'sd0, 8'sd1, 8'sd1, 8'sd0};
    #1;
    check_val("bp_grant", in_ready, 4'b0010);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1; c++;
    end
    check_val("bp_latency", c, 4);
    for (int k = 0; k < 8; k++) begin
      check_val("bp_valid", out_valid, 1);
      check_val("bp_data", out_data, -4);
      check_val("bp_ch", out_ch, 1);
      check_val("bp_busy", busy, 1);
      check_val("bp_noready", in_ready, 0);
      if (k < 7) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release", out_valid, 0);
    check_val("bp_next_ready", in_ready, 4'b0100);
    in_valid = '0;

    // Flush while busy and flush in IDLE
    do_reset();
    do_sample(1, 8'sd1, -4, 1'b0, -1);
    do_sample(1, 8'sd1, -16, 1'b0, 1);
    do_sample(1, 8'sd1, -4, 1'b0, -1);
    do_sample(3, 8'sd1, -4, 1'b0, -1);
    flush = 1'b1;
    in_valid[3] = 1'b1;
    #1;
    check_val("idle_flush_noready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    do_sample(3, 8'sd1, -4, 1'b0, -1);

    // Reset during ACC_BX abandons the sample and clears state and rr
    do_reset();
    do_sample(0, 8'sd1, -4, 1'b0, -1);
    do_sample(1, 8'sd1, -4, 1'b0, -1);
    in_valid[2] = 1'b1;
    in_data[23:16] = 8'sd1;
    #1;
    check_val("abort_grant", in_ready, 4'b0100);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("abort_valid", out_valid, 0);
    check_val("abort_busy", busy, 0);
    rst = 1'b0;
    in_valid = 4'b0101;
    in_data  = {8'sd0, 8'sd1, 8'sd0, 8'sd1};
    #1;
    check_val("abort_rr", in_ready, 4'b0001);
    do_sample(0, 8'sd1, -4, 1'b0, -1);
    do_sample(2, 8'sd1, -4, 1'b0, -1);
    do_sample(1, 8'sd1, -4, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
